// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline's
// Memory stage (CPU) and a secondary requester (DMA: loader / debug port).
//
// The CPU normally has strict priority and is served combinationally in the
// same cycle. The DMA side uses a valid/ready handshake, and read data comes
// back registered with a one-cycle dma_rvalid pulse.
//
// Optional feature, macro DMEM_ARB_STARVE_EN:
//   defined   - a 4-bit starvation counter and a one-cycle FORCE state. After
//               STARVE_MAX consecutive refused DMA cycles, the DMA access is
//               granted once and the CPU is stalled for that one cycle.
//   undefined - strict CPU priority with no counter and no FORCE state.
//               cpu_stall is held at 0, and the DMA may starve.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_valid,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic grant_cpu;
    logic grant_dma;
    logic force_grant;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_FORCE   = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [0:0] state;
    logic [3:0] starve_cnt;
    logic       refused;
    logic       starve_hit;

    // A forced DMA grant only happens when a DMA access is actually waiting.
    // With no DMA access pending, the FORCE cycle behaves like a NORMAL cycle.
    assign force_grant = rst && (state == ST_FORCE) && dma_valid;
    assign refused     = dma_valid && !dma_ready;
    assign starve_hit  = refused && ((starve_cnt + 4'd1) == STARVE_LIM);

    // FORCE lasts exactly one cycle. That keeps cpu_stall from ever being high
    // on two cycles in a row and hands priority straight back to the CPU.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_NORMAL;
        end else if (state == ST_FORCE) begin
            state <= ST_NORMAL;
        end else if (starve_hit) begin
            state <= ST_FORCE;
        end
    end

    // Counts consecutive refused DMA cycles. The count restarts whenever the
    // DMA is granted or the DMA access is withdrawn.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (refused) begin
            starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end
`else
    // Without the starvation guard the FORCE path does not exist.
    // STARVE_MAX is kept only so the parameter list is the same in both builds.
    logic unused_starve_max;
    assign force_grant       = 1'b0;
    assign unused_starve_max = ^STARVE_MAX;
`endif

    // Nobody owns the memory while reset is asserted.
    assign grant_cpu = rst && cpu_req && !force_grant;
    assign grant_dma = rst && dma_valid && (force_grant || !cpu_req);

    // Memory port mux and handshake outputs. When there is no owner the
    // memory port is driven to all zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end else if (grant_dma) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
        dma_ready = grant_dma;
        cpu_stall = force_grant && cpu_req;
    end

    // DMA read data is captured at the edge that ends the grant cycle.
    // dma_rdata keeps its last value between pulses, and reset drops any
    // pending pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= grant_dma && !dma_we;
            if (grant_dma && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, byte address width on all address ports.
REQ-002 Parameter DATA_W, 32, data width on all data ports.
REQ-003 Parameter STARVE_MAX, 4, consecutive refused DMA cycles before a forced DMA grant (range 1..15).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 cpu_req  in  1  Memory-stage access this cycle (load or store).
REQ-007 cpu_we  in  1  Memory-stage store (MemWriteM).
REQ-008 cpu_addr  in  ADDR_W  Memory-stage address (ALUResultM).
REQ-009 cpu_wdata  in  DATA_W  Memory-stage store data (WriteDataM).
REQ-010 cpu_rdata  out  DATA_W  load data to the pipeline (ReadDataM).
REQ-011 cpu_stall  out  1  pipeline SHALL freeze F/D/E/M registers while high.
REQ-012 dma_valid  in  1  secondary requester (loader/debug) has a pending access.
REQ-013 dma_we, dma_addr, dma_wdata  in  1/ADDR_W/DATA_W  secondary access fields, held stable while dma_valid=1 and dma_ready=0.
REQ-014 dma_ready  out  1  secondary access accepted this cycle.
REQ-015 dma_rdata  out  DATA_W  registered read data; dma_rvalid  out  1  one-cycle pulse qualifying dma_rdata.
REQ-016 mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  to single-port data memory (sync write, combinational read); mem_rdata  in  DATA_W.

Function
REQ-017 Exactly one owner per cycle SHALL drive mem_*; with no owner mem_we=0, mem_addr=0, mem_wdata=0.
REQ-018 State machine NORMAL/FORCE; in NORMAL, cpu_req=1 SHALL win: mem_* = cpu_*, cpu_rdata = mem_rdata same cycle, dma_ready=0, cpu_stall=0.
REQ-019 In NORMAL with cpu_req=0 and dma_valid=1, DMA SHALL be granted: mem_* = dma_*, dma_ready=1 (combinational, same cycle).
REQ-020 On a DMA read grant (dma_we=0), dma_rdata SHALL capture mem_rdata at the rising edge ending the grant cycle; dma_rvalid=1 for exactly the next cycle; DMA writes SHALL NOT pulse dma_rvalid.
REQ-021 dma_rdata SHALL hold its last value when dma_rvalid=0.
REQ-022 Starvation counter starve_cnt (4 bits) SHALL increment each cycle dma_valid=1 and dma_ready=0, and clear on any DMA grant or when dma_valid=0.
REQ-023 NORMAL→FORCE when starve_cnt would reach STARVE_MAX at the current edge.
REQ-024 In FORCE with dma_valid=1: DMA granted regardless of cpu_req, dma_ready=1, cpu_stall=cpu_req, cpu_rdata=0; FORCE→NORMAL after one cycle.
REQ-025 In FORCE with dma_valid=0: behave as NORMAL (CPU granted, cpu_stall=0), FORCE→NORMAL.
REQ-026 A stalled CPU access SHALL be serviced in the cycle following FORCE (CPU priority restored); no CPU store may be lost or duplicated.
REQ-027 cpu_stall SHALL never be high two consecutive cycles.

Reset
REQ-028 While rst=0 at a rising edge: state=NORMAL, starve_cnt=0, dma_rvalid=0, dma_rdata=0.
REQ-029 During reset cycles dma_ready=0, cpu_stall=0, mem_we=0; reset mid-FORCE or with a read in flight SHALL drop the pending dma_rvalid pulse.

Configuration
REQ-030 Macro DMEM_ARB_STARVE_EN defined: starve_cnt and FORCE state built per REQ-022..REQ-027.
REQ-031 Macro undefined: no counter, no FORCE state, cpu_stall tied 0, strict CPU priority (DMA may starve); all other requirements unchanged.

Verification
REQ-032 Reset release, CPU store 0x777 to 0x3FC, then CPU load 0x3FC -> cpu_rdata=0x777 same cycle, cpu_stall=0.
REQ-033 cpu_req=0, DMA store 0x54321 to 0x3F8 then DMA load 0x3F8 -> dma_ready=1 each cycle, dma_rvalid=1 with dma_rdata=0x54321 the cycle after the load.
REQ-034 cpu_req=1 continuously, dma_valid=1 (macro on, STARVE_MAX=4) -> dma_ready=1 and cpu_stall=1 in the 5th cycle only, CPU served again in cycle 6; repeat every 5 cycles.
REQ-035 Same stimulus with macro off -> dma_ready=0 and cpu_stall=0 for 20 cycles.
REQ-036 Simultaneous CPU store 0x1 and DMA store 0x2 to 0x100 in the same cycle (NORMAL), then CPU load 0x100 -> reads 0x1; DMA store lands the next free cycle, subsequent load reads 0x2.
REQ-037 Assert rst=0 in the FORCE cycle of a DMA read -> dma_rvalid stays 0, starve_cnt=0, state NORMAL after release.
